// File: rtl/keypad_pkg.sv
// Shared types, default geometry and key indexing for the keypad matrix scanner.
package keypad_pkg;

  localparam int unsigned DEF_NUM_ROWS       = 4;
  localparam int unsigned DEF_NUM_COLS       = 4;
  localparam int unsigned DEF_SETTLE_CYCLES  = 8;
  localparam int unsigned DEF_DEBOUNCE_SCANS = 3;

  typedef enum logic [1:0] {
    S_DRIVE,
    S_SAMPLE,
    S_EVAL
  } scan_state_t;

  function automatic int unsigned key_index(input int unsigned row,
                                            input int unsigned col,
                                            input int unsigned num_cols);
    return row * num_cols + col;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous input bit.
module sync_2ff #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Column-scanning key matrix reader with per-key debounce and one-cycle press/release events.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned NUM_ROWS       = DEF_NUM_ROWS,
  parameter int unsigned NUM_COLS       = DEF_NUM_COLS,
  parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int unsigned DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  enable,
  input  logic [NUM_ROWS-1:0]                   row_in,
  output logic [NUM_COLS-1:0]                   col_out,
  output logic [NUM_ROWS*NUM_COLS-1:0]          key_state,
  output logic                                  key_valid,
  output logic [$clog2(NUM_ROWS*NUM_COLS)-1:0]  key_code,
  output logic                                  key_pressed
);

  localparam int unsigned NUM_KEYS = NUM_ROWS * NUM_COLS;
  localparam int unsigned KW = $clog2(NUM_KEYS);
  localparam int unsigned RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int unsigned CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int unsigned SW = $clog2(SETTLE_CYCLES);
  localparam int unsigned DW = $clog2(DEBOUNCE_SCANS + 1);

  logic [NUM_ROWS-1:0] row_sync;

  // Rows idle high (pulled up), so the synchronizers reset to 1.
  for (genvar r = 0; r < int'(NUM_ROWS); r++) begin : g_row_sync
    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (row_in[r]),
      .q   (row_sync[r])
    );
  end

  scan_state_t           state_q, state_d;
  logic [CW-1:0]         col_idx_q, col_idx_d;
  logic [RW-1:0]         row_idx_q, row_idx_d;
  logic [SW-1:0]         settle_cnt_q, settle_cnt_d;
  logic [NUM_ROWS-1:0]   raw_q, raw_d;
  logic [DW-1:0]         cnt_q [NUM_KEYS];
  logic [DW-1:0]         cnt_d [NUM_KEYS];
  logic [NUM_COLS-1:0]   col_out_q, col_out_d;
  logic [NUM_KEYS-1:0]   key_state_q, key_state_d;
  logic                  key_valid_q, key_valid_d;
  logic [KW-1:0]         key_code_q, key_code_d;
  logic                  key_pressed_q, key_pressed_d;
  logic [KW-1:0]         key_k;
  logic                  raw_bit;

  always_comb begin
    state_d       = state_q;
    col_idx_d     = col_idx_q;
    row_idx_d     = row_idx_q;
    settle_cnt_d  = settle_cnt_q;
    raw_d         = raw_q;
    cnt_d         = cnt_q;
    col_out_d     = col_out_q;
    key_state_d   = key_state_q;
    key_valid_d   = 1'b0;
    key_code_d    = key_code_q;
    key_pressed_d = key_pressed_q;
    key_k         = KW'(key_index(32'(row_idx_q), 32'(col_idx_q), NUM_COLS));
    raw_bit       = raw_q[row_idx_q];

    case (state_q)
      S_DRIVE: begin
        // All columns released means scanning is parked; enable restarts the current column.
        if (&col_out_q) begin
          if (enable) begin
            col_out_d    = ~(NUM_COLS'(1) << col_idx_q);
            settle_cnt_d = '0;
          end
        end else if (settle_cnt_q == SW'(SETTLE_CYCLES - 1)) begin
          settle_cnt_d = '0;
          state_d      = S_SAMPLE;
        end else begin
          settle_cnt_d = settle_cnt_q + SW'(1);
        end
      end
      S_SAMPLE: begin
        raw_d     = ~row_sync;
        row_idx_d = '0;
        state_d   = S_EVAL;
      end
      S_EVAL: begin
        if (raw_bit == key_state_q[key_k]) begin
          cnt_d[key_k] = '0;
        end else if (cnt_q[key_k] == DW'(DEBOUNCE_SCANS - 1)) begin
          cnt_d[key_k]       = '0;
          key_state_d[key_k] = raw_bit;
          key_valid_d        = 1'b1;
          key_code_d         = key_k;
          key_pressed_d      = raw_bit;
        end else begin
          cnt_d[key_k] = cnt_q[key_k] + DW'(1);
        end
        if (row_idx_q == RW'(NUM_ROWS - 1)) begin
          col_idx_d    = (col_idx_q == CW'(NUM_COLS - 1)) ? '0 : col_idx_q + CW'(1);
          settle_cnt_d = '0;
          state_d      = S_DRIVE;
          col_out_d    = enable ? ~(NUM_COLS'(1) << col_idx_d) : '1;
        end else begin
          row_idx_d = row_idx_q + RW'(1);
        end
      end
      default: begin
        state_d = S_DRIVE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_DRIVE;
      col_idx_q     <= '0;
      row_idx_q     <= '0;
      settle_cnt_q  <= '0;
      raw_q         <= '0;
      cnt_q         <= '{default: '0};
      col_out_q     <= '1;
      key_state_q   <= '0;
      key_valid_q   <= 1'b0;
      key_code_q    <= '0;
      key_pressed_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_idx_q     <= col_idx_d;
      row_idx_q     <= row_idx_d;
      settle_cnt_q  <= settle_cnt_d;
      raw_q         <= raw_d;
      cnt_q         <= cnt_d;
      col_out_q     <= col_out_d;
      key_state_q   <= key_state_d;
      key_valid_q   <= key_valid_d;
      key_code_q    <= key_code_d;
      key_pressed_q <= key_pressed_d;
    end
  end

  assign col_out     = col_out_q;
  assign key_state   = key_state_q;
  assign key_valid   = key_valid_q;
  assign key_code    = key_code_q;
  assign key_pressed = key_pressed_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Self-checking bench: a passive key matrix driven from a scan-level debounce reference model.
module tb_keypad_matrix_scanner;

  localparam int NR     = 4;
  localparam int NC     = 4;
  localparam int NK     = NR * NC;
  localparam int SETTLE = 8;
  localparam int DEB    = 3;
  localparam int COLP   = SETTLE + 1 + NR;
  localparam int SCAN   = COLP * NC;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [NR-1:0] row_in;
  logic [NC-1:0] col_out;
  logic [NK-1:0] key_state;
  logic          key_valid;
  logic [3:0]    key_code;
  logic          key_pressed;

  logic [NK-1:0] pressed;
  bit            ref_state [NK];
  int            ref_dis   [NK];
  int            n_vec = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  keypad_matrix_scanner #(
    .NUM_ROWS       (NR),
    .NUM_COLS       (NC),
    .SETTLE_CYCLES  (SETTLE),
    .DEBOUNCE_SCANS (DEB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .row_in      (row_in),
    .col_out     (col_out),
    .key_state   (key_state),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_pressed (key_pressed)
  );

  // Passive matrix: a row is pulled low when a pressed key joins it to a low column.
  always_comb begin
    row_in = '1;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        if (!col_out[c] && pressed[r*NC+c]) row_in[r] = 1'b0;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < NK; k++) begin
      ref_state[k] = 1'b0;
      ref_dis[k]   = 0;
    end
  endtask

  function automatic logic [NK-1:0] ref_vec();
    logic [NK-1:0] v;
    for (int k = 0; k < NK; k++) v[k] = ref_state[k];
    return v;
  endfunction

  // Called at the negedge where column 0 has just started driving; covers one full scan.
  task automatic run_scan(input logic [NK-1:0] pat, input int rst_at);
    bit         exp_v   [SCAN+1];
    int         exp_code[SCAN+1];
    bit         exp_prs [SCAN+1];
    logic [3:0] exp_col;
    int         idx;
    for (int i = 0; i <= SCAN; i++) begin
      exp_v[i] = 1'b0; exp_code[i] = 0; exp_prs[i] = 1'b0;
    end
    pressed = pat;
    // A key flips once it has disagreed with its debounced state for DEB scans in a row.
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < NR; r++) begin
        int k;
        k = r * NC + c;
        if (pat[k] == ref_state[k]) ref_dis[k] = 0;
        else begin
          ref_dis[k]++;
          if (ref_dis[k] == DEB) begin
            ref_state[k] = pat[k];
            ref_dis[k]   = 0;
            idx = SETTLE + 2 + COLP * c + r;
            exp_v[idx] = 1'b1; exp_code[idx] = k; exp_prs[idx] = pat[k];
          end
        end
      end
    for (int i = 1; i <= SCAN; i++) begin
      @(negedge clk);
      exp_col = ~(4'b0001 << ((i / COLP) % NC));
      check_eq("col_out", 32'(col_out), 32'(exp_col));
      check_eq("key_valid", 32'(key_valid), 32'(exp_v[i]));
      if (exp_v[i]) begin
        check_eq("key_code", 32'(key_code), 32'(exp_code[i]));
        check_eq("key_pressed", 32'(key_pressed), 32'(exp_prs[i]));
        check_eq("key_state_evt", 32'(key_state[exp_code[i]]), 32'(exp_prs[i]));
      end
      if (i == rst_at) begin
        rst = 1'b1;
        #1;
        check_eq("rst_mid_valid", 32'(key_valid), 32'd0);
        check_eq("rst_mid_state", 32'(key_state), 32'd0);
        check_eq("rst_mid_col", 32'(col_out), 32'hF);
        return;
      end
    end
    check_eq("key_state_scan", 32'(key_state), 32'(ref_vec()));
  endtask

  task automatic release_reset();
    clear_model();
    rst = 1'b0;
    @(negedge clk);
    check_eq("col_first", 32'(col_out), 32'hE);
  endtask

  initial begin
    logic [NK-1:0] pat;
    int            hold;
    rst     = 1'b1;
    enable  = 1'b1;
    pressed = '0;
    clear_model();
    repeat (3) @(negedge clk);
    check_eq("rst_col_out", 32'(col_out), 32'hF);
    check_eq("rst_key_state", 32'(key_state), 32'd0);
    check_eq("rst_key_valid", 32'(key_valid), 32'd0);
    check_eq("rst_key_code", 32'(key_code), 32'd0);
    check_eq("rst_key_pressed", 32'(key_pressed), 32'd0);
    release_reset();

    // Bounce: key 6 toggles every scan, never stable long enough.
    for (int s = 0; s < 10; s++) run_scan((s % 2 == 0) ? 16'h0040 : 16'h0000, -1);
    check_eq("bounce_key6", 32'(key_state[6]), 32'd0);

    repeat (3) run_scan(16'h0040, -1);
    check_eq("press_key6", 32'(key_state), 32'h0040);
    repeat (3) run_scan(16'h0000, -1);
    check_eq("release_key6", 32'(key_state), 32'h0000);

    repeat (3) run_scan(16'h2002, -1);
    check_eq("press_1_13", 32'(key_state), 32'h2002);
    repeat (3) run_scan(16'h0000, -1);

    // Random holds of 1..5 scans with up to two keys down (no ghost paths).
    for (int b = 0; b < 12; b++) begin
      pat = '0;
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) pat[$urandom_range(0, NK-1)] = 1'b1;
      hold = int'($urandom_range(1, 5));
      for (int s = 0; s < hold; s++) run_scan(pat, -1);
    end
    repeat (DEB) run_scan(16'h0000, -1);
    check_eq("all_released", 32'(key_state), 32'd0);

    // Reset lands in column 2's evaluation on the qualifying scan for key 6.
    repeat (2) run_scan(16'h0040, -1);
    run_scan(16'h0040, SETTLE + 2 + COLP * 2);
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_hold_valid", 32'(key_valid), 32'd0);
      check_eq("rst_hold_state", 32'(key_state), 32'd0);
      check_eq("rst_hold_col", 32'(col_out), 32'hF);
    end
    release_reset();
    repeat (3) run_scan(16'h0040, -1);
    check_eq("repress_key6", 32'(key_state), 32'h0040);

    // Enable drop: column 0 finishes, then the scanner parks with all columns released.
    enable = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      check_eq("dis_col_out", 32'(col_out), (i < COLP) ? 32'hE : 32'hF);
      check_eq("dis_key_valid", 32'(key_valid), 32'd0);
    end
    check_eq("dis_key_state", 32'(key_state), 32'h0040);
    enable = 1'b1;
    for (int i = 1; i <= COLP + 1; i++) begin
      @(negedge clk);
      check_eq("resume_col_out", 32'(col_out), (i <= COLP) ? 32'hD : 32'hB);
      check_eq("resume_key_valid", 32'(key_valid), 32'd0);
    end
    check_eq("resume_key_state", 32'(key_state), 32'h0040);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
